conf_agc: RTL

CONF_AGC -- requirements
Module: conf_agc

---
 rtl/conf_agc_pkg.sv | 16 +
 rtl/conf_agc_if.sv | 18 +
 rtl/conf_att_map.sv | 14 +
 rtl/conf_agc.sv | 124 ++++++++++++
 4 files changed

// File: rtl/conf_agc_pkg.sv
// conf_pkg: AGC loop states, timing/attenuation constants and the saturating tot step
package conf_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, ADJUST} state_t;
    localparam int SETTLE_CYC = 1024;
    localparam int WIN_CYC = 256;
    localparam int LOCK_WIN = 4;
    localparam logic [5:0] ATT_MAX = 6'd61;
    localparam logic [5:0] ATT_INIT = 6'd61;
    localparam logic [5:0] STEP_UP = 6'd2;
    localparam logic [5:0] STEP_DN = 6'd1;
    function automatic logic [5:0] tot_step(input logic [5:0] tot, input logic hi, input logic lo);
        return hi ? ((tot > ATT_MAX - STEP_UP) ? ATT_MAX : tot + STEP_UP)
             : lo ? ((tot < STEP_DN) ? 6'd0 : tot - STEP_DN)
             : tot;
    endfunction
endpackage

// File: rtl/conf_agc_if.sv
// conf_agc_if: control, detector and attenuator signals of the AGC block
interface conf_agc_if;
    logic       en;
    logic       manual;
    logic [1:0] man_att1;
    logic [4:0] man_att2;
    logic       det_hi;
    logic       det_lo;
    logic       pwr_en;
    logic [1:0] att1;
    logic [4:0] att2;
    logic       locked;
    logic       upd;
    modport master (output en, manual, man_att1, man_att2, det_hi, det_lo,
                    input pwr_en, att1, att2, locked, upd);
    modport slave (input en, manual, man_att1, man_att2, det_hi, det_lo,
                   output pwr_en, att1, att2, locked, upd);
endinterface

// File: rtl/conf_att_map.sv
// conf_att_map: splits total attenuation into the 10/20 dB ATT1 code and the 1 dB ATT2 code
module conf_att_map (
    input  logic [5:0] tot,
    output logic [1:0] att1,
    output logic [4:0] att2
);
    always_comb begin
        att1 = tot >= 6'd30 ? 2'd3 : tot >= 6'd20 ? 2'd2 : tot >= 6'd10 ? 2'd1 : 2'd0;
        att2 = tot >= 6'd30 ? 5'(tot - 6'd30)
             : tot >= 6'd20 ? 5'(tot - 6'd20)
             : tot >= 6'd10 ? 5'(tot - 6'd10)
             : tot[4:0];
    end
endmodule

// File: rtl/conf_agc.sv
// conf_agc: detector-driven AGC loop with manual override; CONF_AGC_DBG_EN adds dbg_tot/dbg_state
module conf_agc
    import conf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    conf_agc_if.slave bus
`ifdef CONF_AGC_DBG_EN
    ,
    output logic [5:0] dbg_tot,
    output logic [1:0] dbg_state
`endif
);
    state_t      state_q, state_d;
    logic [9:0]  cyc_q, cyc_d;
    logic [8:0]  hi_q, hi_d, lo_q, lo_d;
    logic [5:0]  tot_q, tot_d;
    logic [2:0]  lock_q, lock_d;
    logic [1:0]  att1_q, att1_d, map_att1;
    logic [4:0]  att2_q, att2_d, map_att2;
    logic        upd_q, upd_d, manual_q;
    logic        hi_s1_q, hi_s2_q, lo_s1_q, lo_s2_q;

    conf_att_map u_map (.tot(tot_d), .att1(map_att1), .att2(map_att2));

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        tot_d   = tot_q;
        lock_d  = lock_q;
        if (!bus.en) begin
            state_d = IDLE;
            cyc_d   = '0;
            hi_d    = '0;
            lo_d    = '0;
            lock_d  = '0;
        end else if (bus.manual) begin
            state_d = state_q;
        end else if (manual_q) begin
            // leaving manual: the interrupted window is discarded
            state_d = MEASURE;
            cyc_d   = '0;
            hi_d    = '0;
            lo_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cyc_d   = '0;
                end
                SETTLE: begin
                    state_d = cyc_q == 10'(SETTLE_CYC - 1) ? MEASURE : SETTLE;
                    cyc_d   = cyc_q == 10'(SETTLE_CYC - 1) ? 10'd0 : cyc_q + 10'd1;
                end
                MEASURE: begin
                    hi_d    = hi_q + {8'd0, hi_s2_q};
                    lo_d    = lo_q + {8'd0, lo_s2_q};
                    state_d = cyc_q == 10'(WIN_CYC - 1) ? ADJUST : MEASURE;
                    cyc_d   = cyc_q == 10'(WIN_CYC - 1) ? 10'd0 : cyc_q + 10'd1;
                end
                ADJUST: begin
                    tot_d   = tot_step(tot_q, hi_q > 9'(WIN_CYC / 2), lo_q > 9'(WIN_CYC / 2));
                    lock_d  = tot_d != tot_q ? 3'd0 : lock_q == 3'(LOCK_WIN) ? lock_q : lock_q + 3'd1;
                    state_d = MEASURE;
                    cyc_d   = '0;
                    hi_d    = '0;
                    lo_d    = '0;
                end
            endcase
        end
    end

    // outputs track the post-adjust tot so they land one cycle after ADJUST
    assign att1_d = bus.manual ? bus.man_att1 : map_att1;
    assign att2_d = bus.manual ? bus.man_att2 : map_att2;
    assign upd_d  = {att1_d, att2_d} != {att1_q, att2_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tot_q    <= ATT_INIT;
            lock_q   <= '0;
            att1_q   <= 2'b11;
            att2_q   <= 5'h1F;
            upd_q    <= 1'b0;
            manual_q <= 1'b0;
            hi_s1_q  <= 1'b0;
            hi_s2_q  <= 1'b0;
            lo_s1_q  <= 1'b0;
            lo_s2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tot_q    <= tot_d;
            lock_q   <= lock_d;
            att1_q   <= att1_d;
            att2_q   <= att2_d;
            upd_q    <= upd_d;
            manual_q <= bus.manual;
            hi_s1_q  <= bus.det_hi;
            hi_s2_q  <= hi_s1_q;
            lo_s1_q  <= bus.det_lo;
            lo_s2_q  <= lo_s1_q;
        end
    end

    assign bus.pwr_en = state_q != IDLE;
    assign bus.att1   = att1_q;
    assign bus.att2   = att2_q;
    assign bus.upd    = upd_q;
    assign bus.locked = lock_q == 3'(LOCK_WIN);

`ifdef CONF_AGC_DBG_EN
    assign dbg_tot   = tot_q;
    assign dbg_state = state_q;
`endif
endmodule
